// File: rtl/dispensador_pkg.sv
// Shared types and default timing for the dispenser actuator controller.
package dispensador_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    COOL   = 3'd2,
    DONE_S = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam int unsigned DEF_MOTOR_MAX = 200;
  localparam int unsigned DEF_COOLDOWN  = 20;

endpackage

// File: rtl/dispensador_ctrl_if.sv
// Request/sensor/status bundle between the vending control logic and the dispenser controller.
interface dispensador_ctrl_if #(
  parameter int unsigned ITEM_W = 8
);
  logic              DISPENSE_REQ;
  logic              ITEM_SENSOR;
  logic              CLR_FAULT;
  logic              MOTOR;
  logic              BUSY;
  logic              DONE;
  logic              FAULT;
  logic [ITEM_W-1:0] ITEM_COUNT;

  modport master (
    output DISPENSE_REQ, ITEM_SENSOR, CLR_FAULT,
    input  MOTOR, BUSY, DONE, FAULT, ITEM_COUNT
  );

  modport slave (
    input  DISPENSE_REQ, ITEM_SENSOR, CLR_FAULT,
    output MOTOR, BUSY, DONE, FAULT, ITEM_COUNT
  );
endinterface

// File: rtl/dispensador_ctrl_sync_rise_det.sv
// Two-flop synchronizer followed by a rising-edge detector; rise_o is one cycle wide.
module sync_rise_det (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic rise_o
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level
  logic [2:0] sh_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/dispensador_ctrl.sv
// Dispenser actuator controller: runs the motor per request, retries missed drops,
// latches a fault after the last retry, and counts delivered items.
module dispensador_ctrl
  import dispensador_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MOTOR_MAX = DEF_MOTOR_MAX,
  parameter int unsigned COOLDOWN  = DEF_COOLDOWN,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned ITEM_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  dispensador_ctrl_if.slave  bus
);

  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_MAX - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRY);

  state_e            state_q;
  logic [CNT_W-1:0]  timer_q;
  logic [RTY_W-1:0]  retry_q;
  logic              got_item_q;
  logic              req_q;
  logic              motor_q;
  logic              busy_q;
  logic              done_q;
  logic              fault_q;
  logic [ITEM_W-1:0] item_cnt_q;
  logic [ITEM_W-1:0] item_cnt_d;
  logic              req_rise;
  logic              item_rise;

  sync_rise_det u_item_det (
    .CLK    (CLK),
    .RST    (RST),
    .d_i    (bus.ITEM_SENSOR),
    .rise_o (item_rise)
  );

  assign req_rise = bus.DISPENSE_REQ & ~req_q;

  always_comb begin
    item_cnt_d = item_cnt_q;
    if (!(&item_cnt_q)) begin
      item_cnt_d = item_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      got_item_q <= 1'b0;
      req_q      <= 1'b0;
      motor_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      item_cnt_q <= '0;
    end else begin
      req_q  <= bus.DISPENSE_REQ;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          motor_q <= 1'b0;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
          if (req_rise) begin
            state_q    <= RUN;
            timer_q    <= '0;
            retry_q    <= '0;
            got_item_q <= 1'b0;
            motor_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        // a drop seen on the timeout cycle still counts as a successful attempt
        RUN: begin
          if (item_rise) begin
            state_q    <= COOL;
            got_item_q <= 1'b1;
            item_cnt_q <= item_cnt_d;
            timer_q    <= '0;
            motor_q    <= 1'b0;
          end else if (timer_q == MOTOR_LAST) begin
            timer_q <= '0;
            motor_q <= 1'b0;
            if (retry_q < RTY_LIMIT) begin
              state_q <= COOL;
              retry_q <= retry_q + 1'b1;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        COOL: begin
          if (timer_q == COOL_LAST) begin
            timer_q <= '0;
            if (got_item_q) begin
              state_q <= DONE_S;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              motor_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        DONE_S: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        FAULT: begin
          if (bus.CLR_FAULT) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          motor_q <= 1'b0;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MOTOR      = motor_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.FAULT      = fault_q;
  assign bus.ITEM_COUNT = item_cnt_q;

  // Output consistency: the motor never runs while idle, faulted or reporting completion.
  a_motor_busy : assert property (@(posedge CLK) disable iff (RST) motor_q |-> busy_q);
  a_fault_off  : assert property (@(posedge CLK) disable iff (RST) fault_q |-> !motor_q);
  a_done_off   : assert property (@(posedge CLK) disable iff (RST) done_q |-> !motor_q);

endmodule

// File: tb/tb_dispensador_ctrl.sv
// Directed bench for dispensador_ctrl with MOTOR_MAX=8, COOLDOWN=4, MAX_RETRY=2, ITEM_W=4.
module tb_dispensador_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  dispensador_ctrl_if #(.ITEM_W(4)) bus ();

  dispensador_ctrl #(
    .CNT_W     (8),
    .MOTOR_MAX (8),
    .COOLDOWN  (4),
    .MAX_RETRY (2),
    .ITEM_W    (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.DISPENSE_REQ = 1'b0;
    bus.ITEM_SENSOR  = 1'b0;
    bus.CLR_FAULT    = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // One complete request with a drop in the first attempt; returns whether DONE pulsed.
  task automatic do_dispense(output bit done_seen);
    done_seen = 1'b0;
    bus.DISPENSE_REQ = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.DONE) done_seen = 1'b1;
    end
    bus.DISPENSE_REQ = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.DISPENSE_REQ = 1'b0;
    bus.ITEM_SENSOR  = 1'b0;
    bus.CLR_FAULT    = 1'b0;
    tick(2);
    n_total++; if (bus.MOTOR !== 1'b0) $display("FAIL reset_motor: got %b expected 0", bus.MOTOR); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.DONE); else n_pass++;
    n_total++; if (bus.FAULT !== 1'b0) $display("FAIL reset_fault: got %b expected 0", bus.FAULT); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h0) $display("FAIL reset_count: got %h expected 0", bus.ITEM_COUNT); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    do_reset();
    bus.DISPENSE_REQ = 1'b1;
    tick(1);
    n_total++; if (bus.MOTOR !== 1'b1) $display("FAIL nom_motor_on: got %b expected 1", bus.MOTOR); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b1) $display("FAIL nom_busy: got %b expected 1", bus.BUSY); else n_pass++;
    tick(1);
    bus.ITEM_SENSOR = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b0;
    n_total++; if (bus.MOTOR !== 1'b1) $display("FAIL nom_motor_before_item: got %b expected 1", bus.MOTOR); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h0) $display("FAIL nom_count_before_item: got %h expected 0", bus.ITEM_COUNT); else n_pass++;
    tick(1);
    n_total++; if (bus.MOTOR !== 1'b0) $display("FAIL nom_motor_cool: got %b expected 0", bus.MOTOR); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL nom_count: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
    tick(3);
    n_total++; if (bus.DONE !== 1'b0) $display("FAIL nom_done_early: got %b expected 0", bus.DONE); else n_pass++;
    tick(1);
    n_total++; if (bus.DONE !== 1'b1) $display("FAIL nom_done_pulse: got %b expected 1", bus.DONE); else n_pass++;
    tick(1);
    n_total++; if (bus.DONE !== 1'b0) $display("FAIL nom_done_end: got %b expected 0", bus.DONE); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL nom_idle_busy: got %b expected 0", bus.BUSY); else n_pass++;
    bus.DISPENSE_REQ = 1'b0;
  endtask

  task automatic test_held_request();
    int done_cnt;
    done_cnt = 0;
    do_reset();
    bus.DISPENSE_REQ = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (bus.DONE) done_cnt++;
      bus.ITEM_SENSOR = ((i % 12) == 2) || ((i % 12) == 3);
    end
    n_total++; if (done_cnt !== 1) $display("FAIL held_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL held_count: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
    bus.DISPENSE_REQ = 1'b0;
    tick(1);
    bus.DISPENSE_REQ = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b0;
    tick(6);
    n_total++; if (bus.ITEM_COUNT !== 4'h2) $display("FAIL held_second_edge_count: got %h expected 2", bus.ITEM_COUNT); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL held_second_idle: got %b expected 0", bus.BUSY); else n_pass++;
    bus.DISPENSE_REQ = 1'b0;
  endtask

  task automatic test_retry();
    int   motor_cnt;
    int   done_at;
    logic m9;
    logic m13;
    motor_cnt = 0;
    done_at   = -1;
    m9        = 1'bx;
    m13       = 1'bx;
    do_reset();
    bus.DISPENSE_REQ = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (bus.MOTOR) motor_cnt++;
      if (bus.DONE) done_at = i;
      if (i == 9) m9 = bus.MOTOR;
      if (i == 13) m13 = bus.MOTOR;
      if (i == 2) bus.DISPENSE_REQ = 1'b0;
      bus.ITEM_SENSOR = (i == 13) || (i == 14);
    end
    n_total++; if (m9 !== 1'b0) $display("FAIL retry_first_cool: got %b expected 0", m9); else n_pass++;
    n_total++; if (m13 !== 1'b1) $display("FAIL retry_second_run: got %b expected 1", m13); else n_pass++;
    n_total++; if (motor_cnt !== 11) $display("FAIL retry_motor_cycles: got %0d expected 11", motor_cnt); else n_pass++;
    n_total++; if (done_at !== 20) $display("FAIL retry_done_cycle: got %0d expected 20", done_at); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL retry_count: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
    n_total++; if (bus.FAULT !== 1'b0) $display("FAIL retry_fault: got %b expected 0", bus.FAULT); else n_pass++;
  endtask

  task automatic test_exhausted();
    bit   ds;
    int   motor_cnt;
    int   rises;
    int   fault_at;
    int   bad;
    logic prev;
    motor_cnt = 0;
    rises     = 0;
    fault_at  = -1;
    bad       = 0;
    prev      = 1'b0;
    do_reset();
    do_dispense(ds);
    bus.DISPENSE_REQ = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick(1);
      if (bus.MOTOR) motor_cnt++;
      if (bus.MOTOR && !prev) rises++;
      prev = bus.MOTOR;
      if (bus.FAULT && fault_at < 0) fault_at = i;
      if (i == 2) bus.DISPENSE_REQ = 1'b0;
    end
    n_total++; if (motor_cnt !== 24) $display("FAIL exh_motor_cycles: got %0d expected 24", motor_cnt); else n_pass++;
    n_total++; if (rises !== 3) $display("FAIL exh_motor_windows: got %0d expected 3", rises); else n_pass++;
    n_total++; if (fault_at !== 33) $display("FAIL exh_fault_cycle: got %0d expected 33", fault_at); else n_pass++;
    n_total++; if (bus.MOTOR !== 1'b0) $display("FAIL exh_motor_off: got %b expected 0", bus.MOTOR); else n_pass++;
    bus.DISPENSE_REQ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!bus.FAULT || bus.MOTOR || !bus.BUSY) bad++;
      if (i == 3) bus.DISPENSE_REQ = 1'b0;
    end
    n_total++; if (bad !== 0) $display("FAIL exh_fault_hold: got %0d bad cycles expected 0", bad); else n_pass++;
    bus.CLR_FAULT = 1'b1;
    tick(1);
    bus.CLR_FAULT = 1'b0;
    n_total++; if (bus.FAULT !== 1'b0) $display("FAIL exh_clear_fault: got %b expected 0", bus.FAULT); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL exh_clear_busy: got %b expected 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL exh_count_kept: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
  endtask

  task automatic test_boundary();
    do_reset();
    bus.DISPENSE_REQ = 1'b1;
    tick(1);
    bus.DISPENSE_REQ = 1'b0;
    tick(5);
    bus.ITEM_SENSOR = 1'b1;
    tick(2);
    n_total++; if (bus.MOTOR !== 1'b1) $display("FAIL bnd_last_run_cycle: got %b expected 1", bus.MOTOR); else n_pass++;
    bus.ITEM_SENSOR = 1'b0;
    tick(1);
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL bnd_count: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
    tick(4);
    n_total++; if (bus.DONE !== 1'b1) $display("FAIL bnd_done: got %b expected 1", bus.DONE); else n_pass++;
    tick(1);
    bus.ITEM_SENSOR = 1'b1;
    tick(2);
    bus.ITEM_SENSOR = 1'b0;
    tick(5);
    n_total++; if (bus.ITEM_COUNT !== 4'h1) $display("FAIL bnd_idle_item: got %h expected 1", bus.ITEM_COUNT); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL bnd_idle_busy: got %b expected 0", bus.BUSY); else n_pass++;
  endtask

  task automatic test_saturation();
    bit ds;
    do_reset();
    for (int i = 0; i < 15; i++) do_dispense(ds);
    n_total++; if (bus.ITEM_COUNT !== 4'hF) $display("FAIL sat_count_15: got %h expected F", bus.ITEM_COUNT); else n_pass++;
    do_dispense(ds);
    n_total++; if (bus.ITEM_COUNT !== 4'hF) $display("FAIL sat_count_16: got %h expected F", bus.ITEM_COUNT); else n_pass++;
    n_total++; if (ds !== 1'b1) $display("FAIL sat_done: got %b expected 1", ds); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ds;
    do_reset();
    do_dispense(ds);
    bus.DISPENSE_REQ = 1'b1;
    tick(1);
    bus.DISPENSE_REQ = 1'b0;
    tick(2);
    rst = 1'b1;
    bus.ITEM_SENSOR = 1'b1;
    tick(1);
    n_total++; if (bus.MOTOR !== 1'b0) $display("FAIL mid_motor: got %b expected 0", bus.MOTOR); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL mid_busy: got %b expected 0", bus.BUSY); else n_pass++;
    n_total++; if (bus.ITEM_COUNT !== 4'h0) $display("FAIL mid_count: got %h expected 0", bus.ITEM_COUNT); else n_pass++;
    tick(2);
    rst = 1'b0;
    bus.ITEM_SENSOR = 1'b0;
    tick(8);
    n_total++; if (bus.ITEM_COUNT !== 4'h0) $display("FAIL mid_item_ignored: got %h expected 0", bus.ITEM_COUNT); else n_pass++;
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL mid_stays_idle: got %b expected 0", bus.BUSY); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.DISPENSE_REQ = 1'b0;
    bus.ITEM_SENSOR  = 1'b0;
    bus.CLR_FAULT    = 1'b0;
    test_reset();
    test_nominal();
    test_held_request();
    test_retry();
    test_exhausted();
    test_boundary();
    test_saturation();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dispensador_ctrl.md
Name: dispensador_ctrl

Overview:
Actuator-side controller for the dispenser. It consumes the dispenser-ready flag produced by the dispenser-verification FSM (DISPENSE_REQ). On each new request it drives the dispense motor, then waits for the item-drop sensor. A missed drop is retried a bounded number of times before the controller latches a fault. It reports completion, fault and a running total of items delivered back to the vending control logic.

Parameters:
CNT_W, 8, width of the motor and cooldown timers; MOTOR_MAX and COOLDOWN must each be ≤ 2^CNT_W.
MOTOR_MAX, 200, motor-on cycles per attempt before the attempt times out.
COOLDOWN, 20, motor-off cycles after an attempt ends.
MAX_RETRY, 2, additional attempts after the first timeout before FAULT (total attempts = MAX_RETRY+1).
ITEM_W, 8, width of the delivered-item counter.

Ports:
CLK  in  1  system clock; all state changes on rising edge.
RST  in  1  synchronous reset, active-high.
DISPENSE_REQ  in  1  level flag from the dispenser-verification FSM; same clock domain, no synchronizer.
ITEM_SENSOR  in  1  asynchronous drop sensor; high while an item passes.
CLR_FAULT  in  1  synchronous fault clear; acts only in FAULT.
MOTOR  out  1  motor drive, registered.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle pulse on successful delivery.
FAULT  out  1  sticky fault indicator.
ITEM_COUNT  out  ITEM_W  total items delivered; saturates at all-ones.

Behaviour:
- Reset (RST=1 at an edge):
  - State becomes IDLE.
  - MOTOR, BUSY, DONE and FAULT become 0.
  - ITEM_COUNT, timer and retry counter become 0.
  - The request-edge register and synchronizer flops clear to 0.
  - Reset mid-operation stops the motor at that edge and does not count a pending item.
- Request edge:
  - req_rise = DISPENSE_REQ & ~req_q, where req_q is DISPENSE_REQ registered.
  - A held-high level triggers exactly one dispense.
  - Edges that occur outside IDLE are dropped, not queued.
- Item edge:
  - ITEM_SENSOR passes through a 2-FF synchronizer, then a rising-edge detector.
  - If ITEM_SENSOR is first sampled high at edge k, item_rise is valid in the cycle after edge k+1 and acts at edge k+2.
  - item_rise outside RUN is ignored and not counted.
- States:
  - IDLE: MOTOR=0. On req_rise: go to RUN, clear timer and retry counter, clear the got_item flag.
  - RUN: MOTOR=1, timer increments every cycle starting from 0.
    - On item_rise: go to COOL, set got_item, increment ITEM_COUNT (saturating), clear timer.
    - Otherwise, at timer==MOTOR_MAX-1 with retry<MAX_RETRY: go to COOL, retry+1, clear timer.
    - Otherwise, at timer==MOTOR_MAX-1 with retry==MAX_RETRY: go to FAULT.
    - The motor is therefore on for exactly MOTOR_MAX cycles per failed attempt.
    - If item_rise and timeout coincide, item_rise wins: the attempt is treated as success.
  - COOL: MOTOR=0, timer counts.
    - At timer==COOLDOWN-1: go to DONE_S if got_item, else back to RUN with timer cleared.
  - DONE_S: DONE=1 for exactly this one cycle, then IDLE. A req_rise in this cycle is ignored.
  - FAULT: FAULT=1, MOTOR=0, BUSY=1.
    - Stays in FAULT until CLR_FAULT=1 at an edge, then goes to IDLE with FAULT=0 at that edge.
    - ITEM_COUNT is retained.
- Output timing: all outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- ITEM_COUNT at its all-ones value stays all-ones; DONE still pulses.
- Unreachable state encodings return to IDLE with MOTOR=0.

Decomposition:
- Shared package dispensador_pkg holds:
  - state encoding localparams: IDLE=3'd0, RUN=3'd1, COOL=3'd2, DONE_S=3'd3, FAULT=3'd4;
  - default timing constants MOTOR_MAX and COOLDOWN.
- One sub-module, sync_rise_det: 2-FF synchronizer plus a rising-edge pulse, with CLK and RST ports. It is instantiated for ITEM_SENSOR.
- Request-edge detection stays inline because DISPENSE_REQ is already synchronous.

Test Plan:
All scenarios use overrides MOTOR_MAX=8, COOLDOWN=4, MAX_RETRY=2, ITEM_W=4.
1. Nominal delivery: req rises at edge 10, ITEM_SENSOR high sampled at edge 13 → MOTOR=1 from edge 11; RUN→COOL at edge 15; ITEM_COUNT=1; DONE high for one cycle after edge 19; then IDLE and BUSY=0.
2. Held request: DISPENSE_REQ held high for 100 cycles with an item each attempt → exactly one DONE and ITEM_COUNT=1; a second 0→1 edge yields ITEM_COUNT=2.
3. Retry then success: no item in first attempt (MOTOR high 8 cycles, low 4), item in second → one DONE, ITEM_COUNT=1, FAULT=0.
4. Exhausted retries: never assert ITEM_SENSOR → 3 motor-on windows of 8 cycles each, then FAULT=1, MOTOR=0. FAULT holds for 50 cycles; CLR_FAULT pulse → IDLE, FAULT=0.
5. Boundary and saturation: item_rise in the same cycle as timer==7 counts as success. 16 successful dispenses leave ITEM_COUNT=4'hF. An item pulse in IDLE leaves the count unchanged.
6. Reset mid-RUN: RST=1 at edge 4 of RUN → MOTOR=0, BUSY=0 and ITEM_COUNT=0 at that edge; an item pulse arriving during reset is not counted.
